// File: rtl/s7seg_mux_if.sv
// Display bus for s7seg_mux: captured BCD/dp inputs toward the driver and
// scanned segment/anode outputs toward the pins.
interface s7seg_mux_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] bcd_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    load;
    logic                    blank_lz;
    logic [6:0]              seg;
    logic                    dp;
    logic [NUM_DIGITS-1:0]   an;
    logic                    frame_done;

    modport master (
        output bcd_in, dp_in, load, blank_lz,
        input  seg, dp, an, frame_done
    );

    modport slave (
        input  bcd_in, dp_in, load, blank_lz,
        output seg, dp, an, frame_done
    );
endinterface

// File: rtl/s7seg_mux.sv
// Time-multiplexed seven-segment driver with tear-free double buffering and
// leading-zero blanking. Define S7SEG_MUX_HEX_EN to show codes 10-15 as A-F.
module s7seg_mux #(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    s7seg_mux_if.slave  bus
);
    localparam int PRE_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PRE_W-1:0]      PRE_LAST = PRE_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_OFF   = {NUM_DIGITS{DIG_ACTIVE_LOW}};

    logic [PRE_W-1:0]        presc_q, presc_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] pend_code_q, pend_code_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic [4*NUM_DIGITS-1:0] disp_code_q, disp_code_d;
    logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d;
    logic                    wrap_q, wrap_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    frame_done_q, frame_done_d;

    logic                    slot_end;
    logic                    wrap;
    logic                    zero_run;
    logic [NUM_DIGITS-1:0]   lead_zero;
    logic [3:0]              cur_code;
    logic                    blank;

    function automatic logic [6:0] decode(input logic [3:0] code);
        case (code)
            4'd0:    decode = 7'b0000001;
            4'd1:    decode = 7'b1001111;
            4'd2:    decode = 7'b0010010;
            4'd3:    decode = 7'b0000110;
            4'd4:    decode = 7'b1001100;
            4'd5:    decode = 7'b0100100;
            4'd6:    decode = 7'b0100000;
            4'd7:    decode = 7'b0001111;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0000100;
`ifdef S7SEG_MUX_HEX_EN
            4'd10:   decode = 7'b0001000;
            4'd11:   decode = 7'b1100000;
            4'd12:   decode = 7'b0110001;
            4'd13:   decode = 7'b1000010;
            4'd14:   decode = 7'b0110000;
            4'd15:   decode = 7'b0111000;
`endif
            default: decode = 7'b1111111;
        endcase
    endfunction

    always_comb begin
        presc_d     = presc_q + 1'b1;
        idx_d       = idx_q;
        pend_code_d = pend_code_q;
        pend_dp_d   = pend_dp_q;
        disp_code_d = disp_code_q;
        disp_dp_d   = disp_dp_q;

        slot_end = (presc_q == PRE_LAST);
        wrap     = slot_end && (idx_q == IDX_LAST);

        if (slot_end) begin
            presc_d = '0;
            idx_d   = wrap ? '0 : idx_q + 1'b1;
        end

        if (bus.load) begin
            pend_code_d = bus.bcd_in;
            pend_dp_d   = bus.dp_in;
        end

        // A load landing on the wrap bypasses pending so it is shown this frame.
        if (wrap) begin
            disp_code_d = bus.load ? bus.bcd_in : pend_code_q;
            disp_dp_d   = bus.load ? bus.dp_in  : pend_dp_q;
        end

        wrap_d = wrap;
    end

    always_comb begin
        zero_run  = 1'b1;
        lead_zero = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run     = zero_run & (disp_code_q[4*i +: 4] == 4'd0) & ~disp_dp_q[i];
            lead_zero[i] = zero_run;
        end

        cur_code = disp_code_q[4*int'(idx_q) +: 4];
        blank    = bus.blank_lz && (idx_q != '0) && lead_zero[idx_q];

        seg_d        = blank ? 7'b1111111 : decode(cur_code);
        dp_d         = blank | ~disp_dp_q[idx_q];
        an_d         = AN_OFF ^ (NUM_DIGITS'(1) << idx_q);
        frame_done_d = wrap_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q      <= '0;
            idx_q        <= '0;
            pend_code_q  <= '0;
            pend_dp_q    <= '0;
            disp_code_q  <= '0;
            disp_dp_q    <= '0;
            wrap_q       <= 1'b0;
            seg_q        <= 7'b1111111;
            dp_q         <= 1'b1;
            an_q         <= AN_OFF;
            frame_done_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            pend_code_q  <= pend_code_d;
            pend_dp_q    <= pend_dp_d;
            disp_code_q  <= disp_code_d;
            disp_dp_q    <= disp_dp_d;
            wrap_q       <= wrap_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.an         = an_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_s7seg_mux.sv
// Scoreboard bench for s7seg_mux: a frame-level reference model queues the
// expected glyphs for each frame, and a monitor checks every cycle of it.
module tb_s7seg_mux;
    localparam int ND    = 4;
    localparam int RD    = 4;
    localparam int FRAME = ND * RD;

    typedef struct packed {
        logic [ND-1:0][6:0] seg;
        logic [ND-1:0]      dp;
    } frame_t;

    logic clk = 1'b0;
    logic rst_n;

    s7seg_mux_if #(.NUM_DIGITS(ND)) bus ();

    s7seg_mux #(
        .NUM_DIGITS    (ND),
        .REFRESH_DIV   (RD),
        .DIG_ACTIVE_LOW(1'b1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    int          frames_checked = 0;
    int unsigned k = 0;
    bit          mon_en   = 1'b0;
    bit          mon_busy = 1'b0;
    frame_t      sb_q[$];

    logic [4*ND-1:0] m_pend, m_disp;
    logic [ND-1:0]   m_pdp, m_ddp;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] glyph(input logic [3:0] c);
        logic [6:0] tbl [16];
        tbl = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                7'b0000000, 7'b0000100, 7'b1111111, 7'b1111111,
                7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111};
`ifdef S7SEG_MUX_HEX_EN
        tbl[10] = 7'b0001000;
        tbl[11] = 7'b1100000;
        tbl[12] = 7'b0110001;
        tbl[13] = 7'b1000010;
        tbl[14] = 7'b0110000;
        tbl[15] = 7'b0111000;
`endif
        return tbl[c];
    endfunction

    // A digit is blanked while every digit from the top down to it is a bare zero.
    function automatic frame_t make_frame(input logic [4*ND-1:0] codes, input logic [ND-1:0] dps,
                                          input logic blz);
        frame_t f;
        bit     all_zero_above = 1'b1;
        logic [3:0] c;
        for (int i = ND - 1; i >= 0; i--) begin
            c = codes[i*4 +: 4];
            all_zero_above = all_zero_above && (c == 4'd0) && !dps[i];
            if (blz && all_zero_above && i != 0) begin
                f.seg[i] = 7'b1111111;
                f.dp[i]  = 1'b1;
            end else begin
                f.seg[i] = glyph(c);
                f.dp[i]  = !dps[i];
            end
        end
        return f;
    endfunction

    // Reference model: loads fill pending; every FRAME cycles the shown frame is replaced.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k      = 0;
            m_pend = '0;
            m_pdp  = '0;
            m_disp = '0;
            m_ddp  = '0;
        end else begin
            k++;
            if (bus.load) begin
                m_pend = bus.bcd_in;
                m_pdp  = bus.dp_in;
            end
            if (k % FRAME == 0) begin
                m_disp = m_pend;
                m_ddp  = m_pdp;
                sb_q.push_back(make_frame(m_disp, m_ddp, bus.blank_lz));
            end
        end
    end

    // Monitor: every frame_done starts a frame that is checked cycle by cycle.
    initial begin
        frame_t exp_f;
        int     idle = 0;
        int     s;
        bit     have;
        forever begin
            @(negedge clk);
            if (!mon_en || !rst_n) begin
                idle = 0;
                continue;
            end
            if (bus.frame_done) begin
                mon_busy = 1'b1;
                idle     = 0;
                have     = (sb_q.size() != 0);
                checkOutput("frame_queue_nonempty", {31'd0, have}, 32'd1);
                if (have) exp_f = sb_q.pop_front();
                for (int c = 0; c < FRAME; c++) begin
                    if (c > 0) @(negedge clk);
                    s = c / RD;
                    checkOutput("an_scan", {28'd0, bus.an}, {28'd0, ~(4'b0001 << s)});
                    checkOutput("frame_done_pulse", {31'd0, bus.frame_done}, (c == 0) ? 32'd1 : 32'd0);
                    if (have) begin
                        checkOutput($sformatf("seg_digit%0d", s), {25'd0, bus.seg}, {25'd0, exp_f.seg[s]});
                        checkOutput($sformatf("dp_digit%0d", s), {31'd0, bus.dp}, {31'd0, exp_f.dp[s]});
                    end
                end
                frames_checked++;
                mon_busy = 1'b0;
            end else begin
                idle++;
                if (idle > FRAME + 4) begin
                    checkOutput("frame_done_timeout", 32'd0, 32'd1);
                    idle = 0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout reached");
        $fatal(1, "[TB] timeout");
    end

    task automatic applyStimulus(input logic [4*ND-1:0] bcd, input logic [ND-1:0] dps, input int cycles);
        bus.bcd_in = bcd;
        bus.dp_in  = dps;
        bus.load   = 1'b1;
        repeat (cycles) @(negedge clk);
        bus.load   = 1'b0;
    endtask

    task automatic waitFramePos(input int unsigned pos);
        for (int i = 0; i <= FRAME + 1; i++) begin
            @(negedge clk);
            if (k % FRAME == pos) return;
        end
        checkOutput("frame_pos_timeout", 32'd0, 32'd1);
    endtask

    task automatic drainMonitor();
        mon_en = 1'b0;
        for (int i = 0; i < 2 * FRAME + 4; i++) begin
            @(negedge clk);
            #1;
            if (!mon_busy) return;
        end
        checkOutput("monitor_drain_timeout", 32'd0, 32'd1);
    endtask

    task automatic restart(input logic blz);
        drainMonitor();
        @(negedge clk);
        rst_n        = 1'b0;
        bus.load     = 1'b0;
        bus.blank_lz = blz;
        sb_q.delete();
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic randomPhase(input int cycles, input bit zero_bias);
        logic [4*ND-1:0] b;
        logic [ND-1:0]   d;
        for (int n = 0; n < cycles; n++) begin
            if ($urandom_range(7) == 0) begin
                for (int i = 0; i < ND; i++) begin
                    if (zero_bias && $urandom_range(1) == 0) b[i*4 +: 4] = 4'd0;
                    else b[i*4 +: 4] = 4'($urandom_range(15));
                    d[i] = ($urandom_range(zero_bias ? 5 : 2) == 0);
                end
                applyStimulus(b, d, $urandom_range(1, 3));
            end else begin
                @(negedge clk);
            end
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.load     = 1'b0;
        bus.bcd_in   = '0;
        bus.dp_in    = '0;
        bus.blank_lz = 1'b0;

        #12;
        checkOutput("reset_seg", {25'd0, bus.seg}, 32'h7F);
        checkOutput("reset_dp", {31'd0, bus.dp}, 32'd1);
        checkOutput("reset_an", {28'd0, bus.an}, 32'hF);
        checkOutput("reset_frame_done", {31'd0, bus.frame_done}, 32'd0);

        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("first_an", {28'd0, bus.an}, 32'hE);
        checkOutput("first_seg", {25'd0, bus.seg}, 32'h01);
        checkOutput("first_frame_done", {31'd0, bus.frame_done}, 32'd0);

        waitFramePos(5);
        applyStimulus(16'h1234, 4'b0000, 1);
        repeat (FRAME) @(negedge clk);
        waitFramePos(FRAME - 1);
        applyStimulus(16'h5678, 4'b0000, 1);
        repeat (FRAME) @(negedge clk);
        waitFramePos(3);
        applyStimulus(16'hFA00, 4'b0001, 2);
        repeat (FRAME) @(negedge clk);
        randomPhase(30 * FRAME, 1'b0);

        restart(1'b1);
        waitFramePos(7);
        applyStimulus(16'h0070, 4'b0000, 1);
        repeat (FRAME) @(negedge clk);
        waitFramePos(9);
        applyStimulus(16'h0070, 4'b0100, 1);
        repeat (FRAME) @(negedge clk);
        waitFramePos(FRAME - 1);
        applyStimulus(16'hFA00, 4'b0000, 1);
        repeat (FRAME) @(negedge clk);
        randomPhase(30 * FRAME, 1'b1);

        // Asynchronous reset in the middle of digit 1's slot, between edges.
        drainMonitor();
        waitFramePos(6);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_seg", {25'd0, bus.seg}, 32'h7F);
        checkOutput("async_dp", {31'd0, bus.dp}, 32'd1);
        checkOutput("async_an", {28'd0, bus.an}, 32'hF);
        checkOutput("async_frame_done", {31'd0, bus.frame_done}, 32'd0);
        sb_q.delete();
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("restart_an", {28'd0, bus.an}, 32'hE);
        checkOutput("restart_seg", {25'd0, bus.seg}, 32'h01);
        repeat (3 * FRAME) @(negedge clk);
        drainMonitor();

        checkOutput("frames_checked_enough", {31'd0, (frames_checked >= 55)}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/s7seg_mux.md
# s7seg_mux

Time-multiplexed driver for a common-anode/cathode bank of NUM_DIGITS seven-segment digits. It accepts one packed BCD word plus per-digit decimal points, latches them without tearing at frame boundaries, and scans one digit at a time at a programmable refresh rate. It is the successor to the single-digit BCD decoder, adding scanning, leading-zero blanking and optional hex glyphs, and sits between the counter/datapath logic and the board display pins.

## Interface
- NUM_DIGITS, 4: digits scanned, 1..8.
- REFRESH_DIV, 50000: clocks per digit slot, >= 2. Prescaler width is $clog2(REFRESH_DIV).
- DIG_ACTIVE_LOW, 1: 1 = anode enable active-low, 0 = active-high.
- clk  input  1  system clock.
- rst_n  input  1  asynchronous, active-low reset.
- bcd_in  input  4*NUM_DIGITS  packed codes; bits [3:0] = digit 0 (least significant).
- dp_in  input  NUM_DIGITS  decimal point request per digit, 1 = lit.
- load  input  1  one-cycle strobe that captures bcd_in/dp_in.
- blank_lz  input  1  enable leading-zero blanking.
- seg  output  7  segments {a,b,c,d,e,f,g} = seg[6:0], active-low.
- dp  output  1  decimal point, active-low.
- an  output  NUM_DIGITS  digit enables, polarity per DIG_ACTIVE_LOW.
- frame_done  output  1  one-cycle pulse when the scan wraps to digit 0.

## Operation
- Prescaler counts 0..REFRESH_DIV-1 and wraps. At its terminal count, digit index idx advances: 0 → 1 → … → NUM_DIGITS-1 → 0.
- Two register banks: pending and display.
  - load writes bcd_in/dp_in into pending.
  - At the idx wrap (NUM_DIGITS-1 → 0), display receives pending.
  - If load and the wrap coincide, display takes bcd_in/dp_in directly, and pending also updates.
  - Display never changes mid-frame.
- Decode of code 0–9, active-low: 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110, 4 = 1001100, 5 = 0100100, 6 = 0100000, 7 = 0001111, 8 = 0000000, 9 = 0000100. Codes 10–15 decode per Configuration.
- Leading-zero blanking, when blank_lz = 1:
  - Digit i is blanked (seg = 1111111) if the display codes of digits NUM_DIGITS-1 down to i are all 0 and none of those digits has dp set.
  - Digit 0 is never blanked.
  - A blanked digit's dp is off.
- An for idx is active; all others are inactive.

## Timing
- Reset values:
  - seg = 1111111, dp = 1, frame_done = 0.
  - an = all inactive.
  - idx = 0, prescaler = 0.
  - pending = display = 0; pending dp = display dp = 0.
- seg, dp, an and frame_done are registered, with one cycle of latency from idx/display.
  - First clock edge after rst_n release: an[0] becomes active and shows digit 0.
  - Each digit is active for exactly REFRESH_DIV cycles.
  - One frame is NUM_DIGITS*REFRESH_DIV cycles.
- frame_done is high for the single cycle in which the digit-0 outputs first appear after a wrap, i.e. the cycle the new display contents become visible.
- load is sampled every cycle; a multi-cycle load simply re-captures. The last value before the wrap wins.
- NUM_DIGITS = 1: every prescaler wrap is a frame wrap, so frame_done pulses every REFRESH_DIV cycles.
- Reset asserted mid-frame forces all reset values immediately, without waiting for clk. The scan restarts at digit 0.
- No dead time between slots: an changes in the same cycle as seg.

## Configuration
- S7SEG_MUX_HEX_EN defined: codes 10–15 display A–F, active-low.
  - A = 0001000, b = 1100000, C = 0110001, d = 1000010, E = 0110000, F = 0111000.
  - Blanking still keys only on code 0.
- Undefined: codes 10–15 display blank (seg = 1111111) with dp unaffected.

## Test plan
- Reset scan: NUM_DIGITS=4, REFRESH_DIV=4, rst_n released → seg = 0000001 on all digits. an (active-low) steps 1110, 1101, 1011, 0111, each for 4 cycles. frame_done pulses every 16 cycles.
- Tear-free load: mid-frame load of bcd_in=16'h1234 → no digit changes until the next frame_done. The following frame shows digit0 = 4 (1001100), digit1 = 3 (0000110), digit2 = 2 (0010010) and digit3 = 1 (1001111).
- Load coincident with wrap, with bcd_in=16'h5678 → that frame_done's frame already displays 5678, with digit0 = 8 (0000000).
- Leading zeros: bcd_in=16'h0070, blank_lz=1 → digits 3 and 2 blank, digit1 = 0001111, digit0 = 0000001. With dp_in=4'b0100, digit 2 shows 0000001 with dp = 0.
- Invalid codes: bcd_in=16'hFA00 → without S7SEG_MUX_HEX_EN, digits 3 and 2 show 1111111. With it, digit3 = 0111000 and digit2 = 0001000.
- Async reset: drop rst_n mid-slot between clock edges → seg = 1111111 and an all inactive before the next clk edge. After release the scan restarts at digit 0 and shows zeros.
